// File: rtl/rate_timer.sv
// -----------------------------------------------------------------------------
// rate_timer
//
// Multi-rate strobe generator. It produces a one-cycle pulse at the end of
// each period. The period for speed index s is P(s) = CLK_HZ / (BASE_HZ << s)
// cycles. The timer runs either periodically or as a one-shot. It supports
// pause (enable_i = 0), a saturating speed-up, a 50 % phase output for LED
// flashing, and a wrapping pulse counter.
//
// Ports
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous, active-low reset
//   load_i     in   1       (re)start at speed_i in mode oneshot_i
//   speed_i    in   SPD_W   speed index sampled on load_i (clamped)
//   oneshot_i  in   1       sampled on load_i: 1 = one-shot, 0 = periodic
//   enable_i   in   1       0 freezes the count and suppresses pulses
//   step_up_i  in   1       speed index + 1, saturating at NUM_RATES-1
//   pulse_o    out  1       one-cycle strobe at each period end
//   phase_o    out  1       high during the first half of each period
//   speed_o    out  SPD_W   current speed index
//   running_o  out  1       timer armed
//   done_o     out  1       sticky one-shot completion flag
//   pcount_o   out  PCNT_W  pulses since the last load, wrapping
// -----------------------------------------------------------------------------
module rate_timer #(
    parameter int  CLK_HZ    = 50_000_000,
    parameter int  BASE_HZ   = 1,
    parameter int  NUM_RATES = 5,
    parameter int  PCNT_W    = 8,
    localparam int SPD_W     = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1,
    localparam int CNT_W     = $clog2(CLK_HZ / BASE_HZ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [SPD_W-1:0]  speed_i,
    input  logic              oneshot_i,
    input  logic              enable_i,
    input  logic              step_up_i,
    output logic              pulse_o,
    output logic              phase_o,
    output logic [SPD_W-1:0]  speed_o,
    output logic              running_o,
    output logic              done_o,
    output logic [PCNT_W-1:0] pcount_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(NUM_RATES - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SPD_W-1:0]    spd, spd_n;
    logic                mode, mode_n;
    logic                done, done_n;
    logic [PCNT_W-1:0]   pcnt, pcnt_n;

    logic                run;
    logic                pulse;
    logic [SPD_W-1:0]    load_spd;

    // Per-speed reload value (P-1) and half-period threshold (P/2). These are
    // built as constant tables so the runtime logic never divides.
    logic [CNT_W-1:0]    reload_tbl [NUM_RATES];
    logic [CNT_W-1:0]    half_tbl   [NUM_RATES];

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_rate
        localparam int P = CLK_HZ / (BASE_HZ << g);
        if (P < 2) begin : g_bad_period
            $error("rate_timer: speed index %0d gives period %0d; at least 2 cycles required", g, P);
        end
        assign reload_tbl[g] = CNT_W'(P - 1);
        assign half_tbl[g]   = CNT_W'(P / 2);
    end

    // Out-of-range speed requests map onto the slowest legal... fastest index.
    function automatic logic [SPD_W-1:0] clamp_speed(input logic [SPD_W-1:0] s);
        if (int'(s) > NUM_RATES - 1) begin
            return SPD_MAX;
        end
        return s;
    endfunction

    function automatic logic [SPD_W-1:0] sat_inc(input logic [SPD_W-1:0] s);
        if (s >= SPD_MAX) begin
            return SPD_MAX;
        end
        return s + SPD_W'(1);
    endfunction

    assign run      = (state == RUN);
    assign pulse    = run && enable_i && (cnt == '0);
    assign load_spd = clamp_speed(speed_i);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= reload_tbl[0];
            spd   <= '0;
            mode  <= 1'b0;
            done  <= 1'b0;
            pcnt  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            spd   <= spd_n;
            mode  <= mode_n;
            done  <= done_n;
            pcnt  <= pcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        spd_n   = spd;
        mode_n  = mode;
        done_n  = done;
        pcnt_n  = pcnt;

        // Speed-up only changes the index; the running count keeps its
        // current period and picks up the new one at the next reload.
        if (step_up_i) begin
            spd_n = sat_inc(spd);
        end

        case (state)
            IDLE: begin
                // Count holds while idle or done.
            end
            RUN: begin
                if (enable_i) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        pcnt_n = pcnt + PCNT_W'(1);
                        cnt_n  = reload_tbl[spd];
                        if (mode) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Load has priority over everything above, including a pulse in
        // this same cycle (the strobe itself is still emitted) and step-up.
        if (load_i) begin
            state_n = RUN;
            cnt_n   = reload_tbl[load_spd];
            spd_n   = load_spd;
            mode_n  = oneshot_i;
            done_n  = 1'b0;
            pcnt_n  = '0;
        end
    end

    assign pulse_o   = pulse;
    assign phase_o   = (cnt >= half_tbl[spd]);
    assign speed_o   = spd;
    assign running_o = run;
    assign done_o    = done;
    assign pcount_o  = pcnt;

endmodule

// File: tb/tb_rate_timer.sv
module tb_rate_timer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load_i, oneshot_i, enable_i, step_up_i;
    logic [1:0] speed_i;
    logic       pulse_o, phase_o, running_o, done_o;
    logic [1:0] speed_o;
    logic [7:0] pcount_o;

    logic       load2, step2;
    logic [1:0] speed2;
    logic       pulse2_o, phase2_o, running2_o, done2_o;
    logic [1:0] speed2_o;
    logic [7:0] pcount2_o;

    rate_timer #(.CLK_HZ(64), .BASE_HZ(1), .NUM_RATES(4), .PCNT_W(8)) dut (
        .clk(clk), .reset(reset), .load_i(load_i), .speed_i(speed_i),
        .oneshot_i(oneshot_i), .enable_i(enable_i), .step_up_i(step_up_i),
        .pulse_o(pulse_o), .phase_o(phase_o), .speed_o(speed_o),
        .running_o(running_o), .done_o(done_o), .pcount_o(pcount_o)
    );

    // Three rates: index 3 is out of range and must clamp to 2.
    rate_timer #(.CLK_HZ(64), .BASE_HZ(1), .NUM_RATES(3), .PCNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .load_i(load2), .speed_i(speed2),
        .oneshot_i(oneshot_i), .enable_i(enable_i), .step_up_i(step2),
        .pulse_o(pulse2_o), .phase_o(phase2_o), .speed_o(speed2_o),
        .running_o(running2_o), .done_o(done2_o), .pcount_o(pcount2_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];
    bit mon_en   = 1'b0;
    int L;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse scoreboard: every expected pulse cycle is queued when the load is
    // driven; any pulse off-schedule or missing is flagged.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                chk("pulse_due", pulse_o, 1);
                void'(exp_q.pop_front());
            end else begin
                chk("pulse_quiet", pulse_o, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0; load_i = 1'b0; step_up_i = 1'b0; load2 = 1'b0; step2 = 1'b0;
        enable_i = 1'b1; oneshot_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_load(input logic [1:0] s, input logic os, input logic st, output int lc);
        @(negedge clk);
        load_i = 1'b1; speed_i = s; oneshot_i = os; step_up_i = st;
        @(negedge clk);
        load_i = 1'b0; step_up_i = 1'b0;
        lc = cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pulse"},   pulse_o,   0);
        chk({tag, "_phase"},   phase_o,   1);
        chk({tag, "_speed"},   speed_o,   0);
        chk({tag, "_running"}, running_o, 0);
        chk({tag, "_done"},    done_o,    0);
        chk({tag, "_pcount"},  pcount_o,  0);
    endtask

    initial begin
        reset = 1'b0; load_i = 1'b0; speed_i = '0; oneshot_i = 1'b0;
        enable_i = 1'b1; step_up_i = 1'b0;
        load2 = 1'b0; speed2 = '0; step2 = 1'b0;

        // Reset state
        do_reset();
        chk_reset_outputs("rst");
        mon_en = 1'b1;

        // Periodic, speed 2 (P=16): pulses at L+15, L+31, L+47
        do_load(2'd2, 1'b0, 1'b0, L);
        for (int i = 1; i <= 3; i++) exp_q.push_back(L + 16 * i - 1);
        chk("per_running", running_o, 1);
        chk("per_speed", speed_o, 2);
        for (int k = 0; k < 48; k++) begin
            chk("per_phase", phase_o, ((k % 16) < 8) ? 1 : 0);
            tick(1);
        end
        chk("per_pcount3", pcount_o, 3);
        chk("per_drained", exp_q.size(), 0);

        // One-shot, speed 3 (P=8): single pulse at L+7
        do_reset();
        do_load(2'd3, 1'b1, 1'b0, L);
        exp_q.push_back(L + 7);
        tick(8);
        chk("os_running", running_o, 0);
        chk("os_done", done_o, 1);
        chk("os_pcount", pcount_o, 1);
        tick(40);
        chk("os_done_sticky", done_o, 1);
        chk("os_drained", exp_q.size(), 0);

        // Speed 0, five step-ups at cycle 10: first pulse at 64, then every 8
        do_reset();
        do_load(2'd0, 1'b0, 1'b0, L);
        exp_q.push_back(L + 63);
        for (int i = 1; i <= 3; i++) exp_q.push_back(L + 63 + 8 * i);
        tick(9);
        step_up_i = 1'b1;
        tick(5);
        step_up_i = 1'b0;
        chk("step_speed_sat", speed_o, 3);
        tick(74);
        chk("step_pcount", pcount_o, 4);
        chk("step_drained", exp_q.size(), 0);

        // Speed 1 (P=32) with a 7-cycle pause from cycle 20: pulse moves to L+38
        do_reset();
        do_load(2'd1, 1'b0, 1'b0, L);
        exp_q.push_back(L + 38);
        tick(20);
        enable_i = 1'b0;
        tick(7);
        chk("pause_running", running_o, 1);
        chk("pause_pcount", pcount_o, 0);
        enable_i = 1'b1;
        tick(12);
        chk("pause_pcount1", pcount_o, 1);
        chk("pause_drained", exp_q.size(), 0);

        // Load together with step-up: load wins; out-of-range index clamps
        do_reset();
        @(negedge clk);
        load_i = 1'b1; speed_i = 2'd3; step_up_i = 1'b1; oneshot_i = 1'b0;
        load2  = 1'b1; speed2  = 2'd3; step2     = 1'b1;
        @(negedge clk);
        load_i = 1'b0; step_up_i = 1'b0; load2 = 1'b0; step2 = 1'b0;
        L = cyc;
        exp_q.push_back(L + 7);
        exp_q.push_back(L + 15);
        exp_q.push_back(L + 23);
        chk("ls_speed", speed_o, 3);
        chk("clamp_speed", speed2_o, 2);
        tick(14);
        chk("clamp_no_early_pulse", pulse2_o, 0);
        tick(1);
        chk("clamp_pulse", pulse2_o, 1);

        // Reset mid-period while running
        tick(1);
        do_reset();
        chk_reset_outputs("midrst");
        chk("midrst_speed3", speed2_o, 0);
        tick(30);
        chk("midrst_idle", running_o, 0);

        // 260 periodic pulses at P=8: pulse counter wraps to 4
        do_load(2'd3, 1'b0, 1'b0, L);
        for (int i = 1; i <= 260; i++) exp_q.push_back(L + 8 * i - 1);
        tick(2080);
        chk("wrap_pcount", pcount_o, 4);
        chk("wrap_running", running_o, 1);
        chk("wrap_drained", exp_q.size(), 0);

        do_reset();
        mon_en = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
